// File: rtl/mem_block_engine.sv
// Bus master that runs COPY / FILL / CHECK block commands over the 256-byte
// data memory, one command at a time, under a start/busy/done handshake.
module mem_block_engine #(
    parameter int RD_WAIT = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [8:0] len,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [8:0] mismatch_count,
    output logic [7:0] address,
    output logic [7:0] writedata,
    output logic       memread,
    output logic       memwrite,
    input  logic [7:0] readdata
);

    // state | meaning
    // IDLE  | waiting for start, strobes low
    // RD    | read access, address held for 1+RD_WAIT cycles
    // WR    | single-cycle write
    // FIN   | one-cycle done pulse, busy low
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [1:0] OP_COPY = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t     r_state;
    logic [7:0] r_src_ptr;
    logic [7:0] r_dst_ptr;
    logic [7:0] r_val;
    logic [8:0] r_cnt;
    logic [1:0] r_op;
    logic [1:0] r_wait;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic [8:0] r_mismatch;
    logic [7:0] r_address;
    logic [7:0] r_writedata;
    logic       r_memread;
    logic       r_memwrite;

    logic [7:0] w_src_next;
    logic [7:0] w_dst_next;
    logic       w_last;

    assign w_src_next = r_src_ptr + 8'd1;
    assign w_dst_next = r_dst_ptr + 8'd1;
    assign w_last     = (r_cnt == 9'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_src_ptr   <= 8'd0;
            r_dst_ptr   <= 8'd0;
            r_val       <= 8'd0;
            r_cnt       <= 9'd0;
            r_op        <= 2'd0;
            r_wait      <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mismatch  <= 9'd0;
            r_address   <= 8'd0;
            r_writedata <= 8'd0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_memread  <= 1'b0;
                    r_memwrite <= 1'b0;
                    if (start) begin
                        r_src_ptr  <= src;
                        r_dst_ptr  <= dst;
                        r_cnt      <= len;
                        r_val      <= value;
                        r_op       <= op;
                        r_mismatch <= 9'd0;
                        if (len == 9'd0 || op == OP_RSVD) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= (op == OP_RSVD);
                        end else if (op == OP_FILL) begin
                            r_state     <= S_WR;
                            r_busy      <= 1'b1;
                            r_memwrite  <= 1'b1;
                            r_address   <= dst;
                            r_writedata <= value;
                        end else begin
                            r_state   <= S_RD;
                            r_busy    <= 1'b1;
                            r_memread <= 1'b1;
                            r_address <= (op == OP_COPY) ? src : dst;
                            r_wait    <= 2'(RD_WAIT);
                        end
                    end
                end
                S_RD: begin
                    if (r_wait != 2'd0) begin
                        r_wait <= r_wait - 2'd1;
                    end else if (r_op == OP_COPY) begin
                        // writedata doubles as the copy buffer
                        r_state     <= S_WR;
                        r_memread   <= 1'b0;
                        r_memwrite  <= 1'b1;
                        r_address   <= r_dst_ptr;
                        r_writedata <= readdata;
                    end else begin
                        if (readdata != r_val && r_mismatch != 9'd256)
                            r_mismatch <= r_mismatch + 9'd1;
                        r_dst_ptr <= w_dst_next;
                        r_cnt     <= r_cnt - 9'd1;
                        if (w_last) begin
                            r_state   <= S_FIN;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_memread <= 1'b0;
                        end else begin
                            r_address <= w_dst_next;
                            r_wait    <= 2'(RD_WAIT);
                        end
                    end
                end
                S_WR: begin
                    r_src_ptr <= w_src_next;
                    r_dst_ptr <= w_dst_next;
                    r_cnt     <= r_cnt - 9'd1;
                    if (w_last) begin
                        r_state    <= S_FIN;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_memwrite <= 1'b0;
                    end else if (r_op == OP_COPY) begin
                        r_state    <= S_RD;
                        r_memwrite <= 1'b0;
                        r_memread  <= 1'b1;
                        r_address  <= w_src_next;
                        r_wait     <= 2'(RD_WAIT);
                    end else begin
                        r_address   <= w_dst_next;
                        r_writedata <= r_val;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign mismatch_count = r_mismatch;
    assign address        = r_address;
    assign writedata      = r_writedata;
    assign memread        = r_memread;
    assign memwrite       = r_memwrite;

endmodule

// File: doc/mem_block_engine.md
Name: mem_block_engine

Overview:
- Bus master for the data_memory port: drives address, writedata, memread and memwrite, and samples readdata.
- Runs block commands (COPY, FILL, CHECK) over the 256-byte data memory, one command at a time, under a start/busy/done handshake.
- Sits between the control logic, or the bench/loader, and data_memory. Used for memory initialisation, block moves and self-check.

Parameters:
- RD_WAIT, 0: extra wait cycles per read. A read access lasts 1+RD_WAIT cycles. Legal range is 0..3.

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous reset, active-high
- start  in  1  command request; sampled only in IDLE
- op  in  2  00=COPY, 01=FILL, 10=CHECK, 11=reserved
- src  in  8  COPY source base address
- dst  in  8  destination (COPY/FILL) or checked region base (CHECK)
- len  in  9  byte count, 0..256
- value  in  8  FILL pattern / CHECK expected byte
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = reserved op
- mismatch_count  out  9  CHECK result; held until next accepted command
- address  out  8  to data_memory
- writedata  out  8  to data_memory
- memread  out  1  to data_memory
- memwrite  out  1  to data_memory
- readdata  in  8  from data_memory

Behaviour:
- Reset, at the clock edge with RESET=1, overrides everything including mid-command:
  - state goes to IDLE
  - busy=0, done=0, err=0, mismatch_count=0
  - address=0, writedata=0, memread=0, memwrite=0
  - no further accesses are issued and the aborted command is not resumed.
- Command operands are latched into internal registers at acceptance. Changes on the inputs while busy have no effect.
- memread and memwrite are never high in the same cycle. Both are 0 outside RD/WR states.
- States are IDLE, RD, WR, FIN.
- IDLE: busy=0.
  - start=1 accepts the command and latches src_ptr=src, dst_ptr=dst, cnt=len, val=value, op.
  - Acceptance also clears mismatch_count.
  - Next state: FIN if len==0 or op==11; RD for COPY/CHECK; WR for FILL.
  - busy goes to 1 from the cycle after acceptance and stays 1 until FIN.
- RD: memread=1, address = src_ptr (COPY) or dst_ptr (CHECK), held stable for 1+RD_WAIT cycles.
  - readdata is captured at the last rising edge of the access.
  - COPY: the byte is stored in buf and the next state is WR.
  - CHECK: if readdata != val, mismatch_count increments (saturates at 256). Then dst_ptr advances and cnt decrements. Next state is RD, or FIN when cnt reaches 0.
- WR: exactly 1 cycle with memwrite=1, address=dst_ptr, writedata = buf (COPY) or val (FILL).
  - After the write, pointers advance and cnt decrements. Next state is RD (COPY) or WR (FILL), or FIN when cnt reaches 0.
- FIN: exactly one cycle with busy=0 and done=1. err=1 only if op==11. Next state is IDLE.
  - start during FIN is ignored; only IDLE accepts a command.
- Throughput: COPY takes 2+RD_WAIT cycles per byte, FILL 1 cycle per byte, CHECK 1+RD_WAIT cycles per byte.
  - The done pulse occurs the cycle after the last access.
  - len==0 (or op==11): done occurs 1 cycle after acceptance, with zero memory accesses.
- Address arithmetic is 8-bit modulo 256. src_ptr and dst_ptr wrap 255→0. len=256 covers the full memory exactly once.
- COPY is always forward (ascending) with a per-byte read-then-write.
  - Overlapping regions with dst>src therefore propagate already-copied bytes. This is defined, required behaviour.
  - Example: src=0, dst=1, len=3 with mem[0]=A yields mem[1..3]=A.
- Outputs are registered. address/writedata hold their last value in IDLE; only the strobes drop.

Test Plan:
- Reset, then FILL dst=0x10 len=4 value=0x5A. Required: 4 consecutive memwrite cycles at 0x10..0x13 with writedata=0x5A. done pulses on cycle 5 after acceptance, err=0.
- After the FILL, COPY src=0x10 dst=0x80 len=4, run at RD_WAIT=0 and at RD_WAIT=2.
  - Required: alternating read/write of 8 cycles (RD_WAIT=0) or 16 cycles (RD_WAIT=2).
  - mem[0x80..0x83]=0x5A afterwards; memread/memwrite never overlap.
- CHECK dst=0x80 len=4 value=0x5A, then poke mem[0x82]=0x00 and repeat. Required: mismatch_count=0, then 1.
- Wrap-around: FILL dst=0xFE len=4 value=0x33. Required: writes at 0xFE, 0xFF, 0x00, 0x01. len=256 CHECK of an all-0x33 memory gives mismatch_count=0.
- Boundary commands:
  - len=0: done one cycle after start, no strobes.
  - op=11: done with err=1.
  - start pulsed while busy: ignored, with no change to the running transfer.
- Reset asserted on the 3rd write of a FILL len=8. Required: next cycle all outputs are at reset values, and bytes 4..8 are never written.
